// File: rtl/registro_universal_multicanal_pkg.sv
// Shared command codes and burst FSM encoding for the multichannel universal register.
package registro_universal_multicanal_pkg;

  localparam logic [1:0] MODO_HOLD  = 2'b00;
  localparam logic [1:0] MODO_LOAD  = 2'b01;
  localparam logic [1:0] MODO_SHIFT = 2'b10;
  localparam logic [1:0] MODO_CLR   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/registro_universal_multicanal_canal.sv
// One N-bit channel register: hold, parallel load, clear, or shift right with the serial bit entering at the MSB.
module registro_canal
  import registro_universal_multicanal_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   i_op,
  input  logic [N-1:0] i_d,
  input  logic         i_sin,
  output logic [N-1:0] o_q
);

  logic [N-1:0] r_q;
  logic [N-1:0] w_q_nx;

  always_comb begin
    w_q_nx = r_q;
    case (i_op)
      MODO_LOAD:  w_q_nx = i_d;
      MODO_CLR:   w_q_nx = '0;
      MODO_SHIFT: w_q_nx = {i_sin, r_q[N-1:1]};
      default:    w_q_nx = r_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_q <= '0;
    else     r_q <= w_q_nx;
  end

  assign o_q = r_q;

endmodule

// File: rtl/registro_universal_multicanal.sv
// Bank of CH channel registers with per-command channel select and an FSM-driven full-duplex serial burst.
module registro_universal_multicanal
  import registro_universal_multicanal_pkg::*;
#(
  parameter int N  = 8,
  parameter int CH = 4,
  parameter int SW = $clog2(CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            h,
  input  logic [1:0]      modo,
  input  logic [SW-1:0]   sel,
  input  logic [N-1:0]    D,
  input  logic            sin,
  output logic [N-1:0]    R,
  output logic [CH*N-1:0] Rall,
  output logic            sout,
  output logic            busy,
  output logic            done
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  state_t          r_state, w_state_nx;
  logic [CW-1:0]   r_cnt, w_cnt_nx;
  logic [SW-1:0]   r_ch, w_ch_nx;
  logic [1:0]      w_op [CH];
  logic [N-1:0]    w_q  [CH];

  // Commands are only honoured in IDLE; the accept edge of a burst only latches, it does not shift.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_ch_nx    = r_ch;
    case (r_state)
      ST_IDLE: begin
        if (h && (modo == MODO_SHIFT)) begin
          w_state_nx = ST_SHIFT;
          w_cnt_nx   = '0;
          w_ch_nx    = sel;
        end
      end
      ST_SHIFT: begin
        w_cnt_nx = r_cnt + CW'(1);
        if (r_cnt == CNT_LAST) w_state_nx = ST_DONE;
      end
      ST_DONE:  w_state_nx = ST_IDLE;
      default:  w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_ch    <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_ch    <= w_ch_nx;
    end
  end

  always_comb begin
    for (int k = 0; k < CH; k++) begin
      w_op[k] = MODO_HOLD;
      if ((r_state == ST_IDLE) && h && (sel == SW'(k))) begin
        if ((modo == MODO_LOAD) || (modo == MODO_CLR)) w_op[k] = modo;
      end else if ((r_state == ST_SHIFT) && (r_ch == SW'(k))) begin
        w_op[k] = MODO_SHIFT;
      end
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_canal
    registro_canal #(.N(N)) u_canal (
      .clk   (clk),
      .rst   (rst),
      .i_op  (w_op[k]),
      .i_d   (D),
      .i_sin (sin),
      .o_q   (w_q[k])
    );
    assign Rall[k*N +: N] = w_q[k];
  end

  assign R    = w_q[sel];
  assign busy = (r_state == ST_SHIFT);
  assign done = (r_state == ST_DONE);
  assign sout = busy ? w_q[r_ch][0] : 1'b0;

endmodule

// File: tb/tb_registro_universal_multicanal.sv
// Directed self-checking bench for the multichannel universal register (N=8, CH=4).
module tb_registro_universal_multicanal;

  logic        clk = 1'b0;
  logic        rst;
  logic        h;
  logic [1:0]  modo;
  logic [1:0]  sel;
  logic [7:0]  D;
  logic        sin;
  logic [7:0]  R;
  logic [31:0] Rall;
  logic        sout;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  registro_universal_multicanal #(.N(8), .CH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .h    (h),
    .modo (modo),
    .sel  (sel),
    .D    (D),
    .sin  (sin),
    .R    (R),
    .Rall (Rall),
    .sout (sout),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [1:0] m, input logic [1:0] s, input logic [7:0] d);
    h = 1'b1; modo = m; sel = s; D = d;
    tick();
    h = 1'b0; modo = 2'b00;
  endtask

  task automatic test_reset();
    rst = 1'b1; h = 1'b0; modo = 2'b00; sel = 2'd0; D = 8'h00; sin = 1'b0;
    tick(); tick();
    rst = 1'b0;
    cmd(2'b01, 2'd0, 8'h55);
    cmd(2'b01, 2'd1, 8'h66);
    if (Rall !== 32'h0000_6655) begin failures++; $display("FAIL reset_preload Rall=%h exp=%h", Rall, 32'h0000_6655); end
    checks++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if (Rall !== 32'h0) begin failures++; $display("FAIL reset_rall Rall=%h exp=0", Rall); end
    checks++;
    if ({busy, done, sout} !== 3'b000) begin failures++; $display("FAIL reset_flags busy/done/sout=%b exp=000", {busy, done, sout}); end
    checks++;
  endtask

  task automatic test_load_hold();
    cmd(2'b01, 2'd2, 8'hA5);
    h = 1'b0; modo = 2'b01; D = 8'hFF; sel = 2'd2;
    repeat (5) tick();
    modo = 2'b00;
    if (R !== 8'hA5) begin failures++; $display("FAIL load_R R=%h exp=a5", R); end
    checks++;
    if (Rall !== 32'h00A5_0000) begin failures++; $display("FAIL load_hold_rall Rall=%h exp=00a50000", Rall); end
    checks++;
    sel = 2'd0; #1;
    if (R !== 8'h00) begin failures++; $display("FAIL load_R_other R=%h exp=00", R); end
    checks++;
  endtask

  task automatic test_burst();
    logic [7:0] sin_pat;
    logic [7:0] sout_exp;
    int busy_cnt;
    sin_pat  = 8'h4D;
    sout_exp = 8'h3C;
    busy_cnt = 0;
    cmd(2'b01, 2'd1, 8'h3C);
    cmd(2'b10, 2'd1, 8'h00);
    for (int i = 0; i < 8; i++) begin
      if (busy === 1'b1) busy_cnt++;
      if (sout !== sout_exp[i]) begin failures++; $display("FAIL burst_sout bit%0d sout=%b exp=%b", i, sout, sout_exp[i]); end
      checks++;
      sin = sin_pat[i];
      tick();
    end
    sin = 1'b0;
    if (busy_cnt != 8) begin failures++; $display("FAIL burst_busy_len cycles=%0d exp=8", busy_cnt); end
    checks++;
    if ({busy, done} !== 2'b01) begin failures++; $display("FAIL burst_done busy/done=%b exp=01", {busy, done}); end
    checks++;
    tick();
    if ({busy, done} !== 2'b00) begin failures++; $display("FAIL burst_done_pulse busy/done=%b exp=00", {busy, done}); end
    checks++;
    if (Rall !== 32'h00A5_4D00) begin failures++; $display("FAIL burst_result Rall=%h exp=00a54d00", Rall); end
    checks++;
  endtask

  task automatic test_ignore_busy();
    logic [7:0] sin_pat;
    logic [7:0] sout_exp;
    sin_pat  = 8'hB2;
    sout_exp = 8'h4D;
    cmd(2'b01, 2'd0, 8'h5A);
    cmd(2'b10, 2'd1, 8'h00);
    for (int i = 0; i < 8; i++) begin
      if (sout !== sout_exp[i]) begin failures++; $display("FAIL busy_sout bit%0d sout=%b exp=%b", i, sout, sout_exp[i]); end
      checks++;
      h = 1'b0; modo = 2'b00; sel = 2'd3;
      if (i == 2) begin h = 1'b1; modo = 2'b01; sel = 2'd0; D = 8'hFF; end
      if (i == 4) begin h = 1'b1; modo = 2'b11; sel = 2'd1; end
      sin = sin_pat[i];
      tick();
    end
    h = 1'b0; modo = 2'b00; sin = 1'b0; sel = 2'd0;
    if (done !== 1'b1) begin failures++; $display("FAIL busy_done done=%b exp=1", done); end
    checks++;
    tick();
    if (R !== 8'h5A) begin failures++; $display("FAIL busy_ch0 R=%h exp=5a", R); end
    checks++;
    if (Rall !== 32'h00A5_B25A) begin failures++; $display("FAIL busy_rall Rall=%h exp=00a5b25a", Rall); end
    checks++;
  endtask

  task automatic test_reset_mid_burst();
    int done_seen;
    done_seen = 0;
    cmd(2'b10, 2'd2, 8'h00);
    sin = 1'b1;
    repeat (3) tick();
    if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy busy=%b exp=1", busy); end
    checks++;
    rst = 1'b1;
    tick();
    rst = 1'b0; sin = 1'b0;
    if (Rall !== 32'h0) begin failures++; $display("FAIL mid_rall Rall=%h exp=0", Rall); end
    checks++;
    if ({busy, done, sout} !== 3'b000) begin failures++; $display("FAIL mid_flags busy/done/sout=%b exp=000", {busy, done, sout}); end
    checks++;
    for (int i = 0; i < 10; i++) begin
      if (done === 1'b1) done_seen++;
      tick();
    end
    if (done_seen != 0) begin failures++; $display("FAIL mid_no_done pulses=%0d exp=0", done_seen); end
    checks++;
    cmd(2'b01, 2'd3, 8'h81);
    if (Rall !== 32'h8100_0000) begin failures++; $display("FAIL mid_load Rall=%h exp=81000000", Rall); end
    checks++;
  endtask

  task automatic test_back_to_back();
    cmd(2'b01, 2'd0, 8'h11);
    if (Rall[7:0] !== 8'h11) begin failures++; $display("FAIL b2b_load ch0=%h exp=11", Rall[7:0]); end
    checks++;
    cmd(2'b11, 2'd0, 8'h00);
    if (Rall[7:0] !== 8'h00) begin failures++; $display("FAIL b2b_clear ch0=%h exp=00", Rall[7:0]); end
    checks++;
    cmd(2'b01, 2'd1, 8'hF0);
    cmd(2'b10, 2'd1, 8'h00);
    sin = 1'b0;
    repeat (8) tick();
    if (done !== 1'b1) begin failures++; $display("FAIL b2b_done done=%b exp=1", done); end
    checks++;
    h = 1'b1; modo = 2'b10; sel = 2'd1;
    tick();
    if (busy !== 1'b0) begin failures++; $display("FAIL b2b_done_ignored busy=%b exp=0", busy); end
    checks++;
    if (Rall[15:8] !== 8'h00) begin failures++; $display("FAIL b2b_ch1_zero ch1=%h exp=00", Rall[15:8]); end
    checks++;
    tick();
    h = 1'b0; modo = 2'b00;
    if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept busy=%b exp=1", busy); end
    checks++;
    sin = 1'b1;
    repeat (8) tick();
    sin = 1'b0;
    tick();
    if (Rall !== 32'h8100_FF00) begin failures++; $display("FAIL b2b_final Rall=%h exp=8100ff00", Rall); end
    checks++;
  endtask

  initial begin
    test_reset();
    test_load_hold();
    test_burst();
    test_ignore_busy();
    test_reset_mid_burst();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
